// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter
//   Shares the single read channel of the program memory between the CPU
//   instruction fetch (port A) and memory-system program-space reads (port B).
//   One transaction is outstanding at a time. Contention is resolved round-robin,
//   and no grant is given until the memory reports that the ROM load is done.
//   A watchdog turns a read that never returns into an error acknowledgement.
//
// Ports
//   clk_in, rst_in        clock, asynchronous active-high reset
//   req_a/addr_a          port A request (held until ack_a) and address
//   ack_a/err_a/rdata_a   port A one-cycle completion, timeout flag, read data
//   req_b ... rdata_b     same as port A, for port B
//   mem_ready             program memory loaded; gates new grants only
//   mem_req/mem_addr      one-cycle read strobe and held address to memory
//   mem_valid/mem_rdata   one-cycle data-valid and data from memory
//   busy                  high whenever the arbiter is not idle
//
// Every output comes straight from a flop.
module program_memory_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   output logic              ack_a,
   output logic              err_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   output logic              ack_b,
   output logic              err_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t            state, state_nx;
   port_t             owner, owner_nx;
   port_t             last_grant, last_grant_nx;
   port_t             grant;
   logic [15:0]       timer, timer_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic              mem_req_nx;
   logic              ack_a_nx, ack_b_nx, err_a_nx, err_b_nx;
   logic [DATA_W-1:0] rdata_a_nx, rdata_b_nx;
   logic              busy_nx;
   logic              finish, timed_out;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= S_IDLE;
         owner      <= PORT_A;
         last_grant <= PORT_B;
         timer      <= '0;
         mem_addr   <= '0;
         mem_req    <= 1'b0;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         err_a      <= 1'b0;
         err_b      <= 1'b0;
         rdata_a    <= '0;
         rdata_b    <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         last_grant <= last_grant_nx;
         timer      <= timer_nx;
         mem_addr   <= mem_addr_nx;
         mem_req    <= mem_req_nx;
         ack_a      <= ack_a_nx;
         ack_b      <= ack_b_nx;
         err_a      <= err_a_nx;
         err_b      <= err_b_nx;
         rdata_a    <= rdata_a_nx;
         rdata_b    <= rdata_b_nx;
         busy       <= busy_nx;
      end
   end

   // Outputs are registered, so the completion strobes are loaded on the
   // WAIT->DONE transition and are therefore visible during DONE.
   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      last_grant_nx = last_grant;
      timer_nx      = timer;
      mem_addr_nx   = mem_addr;
      mem_req_nx    = 1'b0;
      ack_a_nx      = 1'b0;
      ack_b_nx      = 1'b0;
      err_a_nx      = 1'b0;
      err_b_nx      = 1'b0;
      rdata_a_nx    = rdata_a;
      rdata_b_nx    = rdata_b;
      grant         = PORT_A;
      finish        = 1'b0;
      timed_out     = 1'b0;

      case (state)
         S_IDLE: begin
            if (mem_ready && (req_a || req_b)) begin
               if (req_a && req_b)
                  grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
               else
                  grant = req_a ? PORT_A : PORT_B;
               owner_nx      = grant;
               last_grant_nx = grant;
               mem_addr_nx   = (grant == PORT_A) ? addr_a : addr_b;
               mem_req_nx    = 1'b1;
               state_nx      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            timer_nx = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            // Data arriving on the last permitted cycle still counts as good.
            if (mem_valid || timer == TIMER_LAST) begin
               finish    = 1'b1;
               timed_out = !mem_valid;
            end else begin
               timer_nx = timer + 16'd1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      if (finish) begin
         state_nx = S_DONE;
         if (owner == PORT_A) begin
            ack_a_nx   = 1'b1;
            err_a_nx   = timed_out;
            rdata_a_nx = timed_out ? '0 : mem_rdata;
         end else begin
            ack_b_nx   = 1'b1;
            err_b_nx   = timed_out;
            rdata_b_nx = timed_out ? '0 : mem_rdata;
         end
      end

      busy_nx = (state_nx != S_IDLE);
   end

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
- Shares the single-ported program memory read channel between two requesters:
  - Port A: CPU instruction fetch.
  - Port B: memory-system data reads of program space.
- Sits between the program memory and its two consumers.
- Serialises reads with round-robin grant and one outstanding transaction.
- Blocks all grants until the program memory reports the ROM load is complete.
- A watchdog converts hung reads into error acknowledgements.

Parameters:
- ADDR_W, 16, program memory address width.
- DATA_W, 32, instruction/data word width.
- TIMEOUT, 255, max WAIT cycles before error completion; range 1..65535; counter is 16 bits.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- req_a  input  1  port A read request; held until ack_a.
- addr_a  input  ADDR_W  port A address; stable while req_a high.
- ack_a  output  1  one-cycle completion pulse for port A.
- err_a  output  1  valid with ack_a; 1 = timed out.
- rdata_a  output  DATA_W  read data; valid with ack_a.
- req_b, addr_b, ack_b, err_b, rdata_b: same as port A, for port B.
- mem_ready  input  1  program memory loaded and serviceable.
- mem_req  output  1  one-cycle read strobe to program memory.
- mem_addr  output  ADDR_W  address to program memory; held ISSUE through WAIT.
- mem_valid  input  1  one-cycle data-valid from program memory.
- mem_rdata  input  DATA_W  data from program memory; sampled when mem_valid=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release):
  - state=IDLE.
  - ack_a/ack_b/err_a/err_b/mem_req/busy=0.
  - rdata_a/rdata_b/mem_addr=0, timer=0.
  - last_grant=B, so A wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If mem_ready=0, stay and grant nothing.
  - Otherwise, if exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant.
  - On grant: latch owner, mem_addr<=owner's addr, last_grant<=owner, go to ISSUE.
- ISSUE:
  - mem_req=1 for exactly this cycle.
  - mem_valid is ignored in this state; memory latency is at least 1.
  - timer<=0; go to WAIT.
- WAIT:
  - If mem_valid=1: capture mem_rdata, err=0, go to DONE.
  - Else if timer==TIMEOUT-1: capture 0, err=1, go to DONE.
  - Else timer<=timer+1.
  - If mem_valid and timeout coincide, mem_valid wins (err=0).
- DONE:
  - The owner's ack=1, err and rdata as captured; the other port's ack=0.
  - Go to IDLE next cycle.
- Requester protocol: drop req on the edge that samples ack=1. A req still high in the following IDLE is treated as a new request.
- rdata_x holds its last captured value between acks.
- A req dropped after grant is a protocol violation. The transaction still completes and acks.
- Latency:
  - req seen in IDLE at cycle 0 → mem_req at cycle 1.
  - Earliest mem_valid at cycle 2 → ack at cycle 3.
  - Back-to-back throughput: one read per 4 cycles minimum.
- mem_ready falling mid-transaction does not abort; it only gates new grants.
- Reset mid-transaction: immediate IDLE, all strobes low, no ack issued. In-flight mem_valid after reset is ignored.
- addr_x changes while req_x is high but not yet granted: the value sampled at grant is used.

Test Plan:
- Single read:
  - Stimulus: mem_ready=1, req_a with addr_a=0x0040; memory returns 0xDEADBEEF one cycle after mem_req.
  - Required: mem_req at cycle 1 with mem_addr=0x0040; ack_a at cycle 3 with rdata_a=0xDEADBEEF, err_a=0; ack_b never asserted.
- Contention:
  - Stimulus: req_a and req_b held continuously; addr_a=0x10, addr_b=0x20.
  - Required: mem_addr sequence 0x10, 0x20, 0x10, 0x20; acks alternate A, B, A, B.
- ROM load gating:
  - Stimulus: mem_ready=0 for 50 cycles with req_b high, then mem_ready=1.
  - Required: no mem_req and busy=0 during the 50 cycles; mem_req exactly 1 cycle after mem_ready rises.
- Timeout:
  - Stimulus: TIMEOUT=8, mem_valid never asserted.
  - Required: ack_a with err_a=1 and rdata_a=0 exactly 8 cycles after entering WAIT (cycle 10).
  - Repeat with mem_valid on the 8th WAIT cycle → err_a=0 and data captured.
- Reset mid-WAIT:
  - Stimulus: rst_in pulsed in the 3rd WAIT cycle; mem_valid arrives one cycle later.
  - Required: all outputs zero during reset; no ack after release; next req_a served normally, with A winning if both request.
- Protocol edge:
  - Stimulus: requester holds req_a for one cycle after ack_a.
  - Required: a second read is issued to the same address, with its own ack.
